adc_sampler: RTL and testbench



---
 rtl/adc_pkg.sv | 50 +++++
 rtl/adc_spi_shifter.sv | 108 ++++++++++
 rtl/adc_sampler.sv | 145 ++++++++++++++
 tb/tb_adc_sampler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308 continuous-conversion sampler.
// Contents: FSM state encoding, SPI frame geometry, config-word bit positions,
// the config-word builder and the sample payload struct.
package adc_pkg;

  localparam int unsigned SHIFT_BITS = 12;  // bits per SPI transfer
  localparam int unsigned CFG_BITS   = 6;   // config word length (sent first)
  localparam int unsigned CH_W       = 3;   // channel select width
  localparam int unsigned SAMPLE_W   = 12;  // ADC result width

  // Config-word bit positions; bit 5 leaves the shifter first.
  localparam int unsigned CFG_SD  = 5;
  localparam int unsigned CFG_OS  = 4;
  localparam int unsigned CFG_S1  = 3;
  localparam int unsigned CFG_S0  = 2;
  localparam int unsigned CFG_UNI = 1;
  localparam int unsigned CFG_SLP = 0;

  // Unipolar input range, never sleep between conversions.
  localparam logic CFG_UNI_VAL = 1'b1;
  localparam logic CFG_SLP_VAL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVST  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Result handed downstream: data plus the channel that produced it.
  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [SAMPLE_W-1:0] data;
  } sample_t;

  // Single-ended, unipolar config word for a channel number.
  function automatic logic [CFG_BITS-1:0] build_cfg(input logic [CH_W-1:0] ch);
    logic [CFG_BITS-1:0] cfg;
    cfg          = '0;
    cfg[CFG_SD]  = 1'b1;
    cfg[CFG_OS]  = ch[0];
    cfg[CFG_S1]  = ch[2];
    cfg[CFG_S0]  = ch[1];
    cfg[CFG_UNI] = CFG_UNI_VAL;
    cfg[CFG_SLP] = CFG_SLP_VAL;
    return cfg;
  endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// 12-bit SPI shift engine, SCK = clk/2, idle low.
// Each bit: phase 0 drives SDI with SCK low, phase 1 raises SCK; SDO is
// captured on the clk edge that ends phase 1 (one clk after the SCK rise).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start_i      pulse: load cfg_i and begin bit 0 on the next cycle
//   abort_i      drop any transfer in flight, SCK/SDI low
//   cfg_i        6-bit config word, sent MSB first, zeros afterwards
//   sdo_i        serial data from the ADC
//   sck_o, sdi_o registered SPI outputs
//   data_o       received word, complete the cycle after done_c_o
//   done_c_o     high in the final phase-1 cycle (combinational)
module adc_spi_shifter
  import adc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CFG_BITS-1:0]   cfg_i,
  input  logic                  sdo_i,
  output logic                  sck_o,
  output logic                  sdi_o,
  output logic [SHIFT_BITS-1:0] data_o,
  output logic                  done_c_o
);

  localparam int unsigned BIT_W = $clog2(SHIFT_BITS);

  logic                  active_q,  active_d;
  logic                  phase_q,   phase_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CFG_BITS-1:0]   cfg_q,     cfg_d;
  logic [SHIFT_BITS-1:0] data_q,    data_d;
  logic                  sck_q,     sck_d;
  logic                  sdi_q,     sdi_d;
  logic                  last_bit_c;

  assign last_bit_c = (bit_cnt_q == BIT_W'(SHIFT_BITS - 1));
  assign done_c_o   = active_q & phase_q & last_bit_c & ~abort_i;

  // Next-state: abort beats start beats normal shifting.
  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    cfg_d     = cfg_q;
    data_d    = data_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    if (abort_i) begin
      active_d = 1'b0;
      phase_d  = 1'b0;
      sck_d    = 1'b0;
      sdi_d    = 1'b0;
    end else if (start_i) begin
      active_d  = 1'b1;
      phase_d   = 1'b0;
      bit_cnt_d = '0;
      sck_d     = 1'b0;
      sdi_d     = cfg_i[CFG_BITS-1];
      cfg_d     = {cfg_i[CFG_BITS-2:0], 1'b0};
    end else if (active_q) begin
      if (!phase_q) begin
        phase_d = 1'b1;
        sck_d   = 1'b1;
      end else begin
        phase_d = 1'b0;
        sck_d   = 1'b0;
        data_d  = {data_q[SHIFT_BITS-2:0], sdo_i};
        if (last_bit_c) begin
          active_d = 1'b0;
          sdi_d    = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          // Zeros shifted in behind the config bits give SDI=0 for bits 6..11.
          sdi_d     = cfg_q[CFG_BITS-1];
          cfg_d     = {cfg_q[CFG_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      cfg_q     <= '0;
      data_q    <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_q     <= cfg_d;
      data_q    <= data_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
    end
  end

  assign sck_o  = sck_q;
  assign sdi_o  = sdi_q;
  assign data_o = data_q;

endmodule

// File: rtl/adc_sampler.sv
// Continuous-conversion controller for the LTC2308 SAR ADC.
// Frame: CONVST pulse, conversion wait, 12-bit SPI transfer, one DONE cycle.
// The word read in a frame was converted with the config written in the
// previous frame, so the first frame after enable is always discarded.
// Ports:
//   clk, rst_n       40 MHz ADC clock, async active-low reset
//   enable           PLL lock; sampling runs only while high
//   channel          requested channel, latched when SHIFT starts
//   adc_convst       ADC CONVST
//   adc_sck, adc_sdi SPI clock (idle low) and config data out
//   adc_sdo          SPI result data in
//   sample           last valid 12-bit result
//   sample_channel   channel that produced sample
//   sample_valid     one-cycle strobe when sample/sample_channel update
module adc_sampler
  import adc_pkg::*;
#(
  parameter int unsigned CONVST_CYCLES = 2,
  parameter int unsigned CONV_CYCLES   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CH_W-1:0]     channel,
  output logic                adc_convst,
  output logic                adc_sck,
  output logic                adc_sdi,
  input  logic                adc_sdo,
  output logic [SAMPLE_W-1:0] sample,
  output logic [CH_W-1:0]     sample_channel,
  output logic                sample_valid
);

  localparam int unsigned CNT_MAX = (CONV_CYCLES > CONVST_CYCLES) ? CONV_CYCLES : CONVST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                convst_q;
  logic                discard_q;
  logic [CH_W-1:0]     cfg_ch_q;   // channel written to the ADC this frame
  logic [CH_W-1:0]     res_ch_q;   // channel the word being read belongs to
  sample_t             sample_q;
  logic                valid_q;

  logic                  spi_start_c;
  logic                  spi_abort_c;
  logic                  spi_done_c;
  logic [CFG_BITS-1:0]   spi_cfg_c;
  logic [SHIFT_BITS-1:0] spi_data;

  // The shifter loads on the same edge the FSM enters SHIFT.
  assign spi_start_c = enable & (state_q == ST_CONVERT) & (cnt_q == '0);
  assign spi_abort_c = ~enable;
  assign spi_cfg_c   = build_cfg(channel);

  adc_spi_shifter u_spi (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (spi_start_c),
    .abort_i  (spi_abort_c),
    .cfg_i    (spi_cfg_c),
    .sdo_i    (adc_sdo),
    .sck_o    (adc_sck),
    .sdi_o    (adc_sdi),
    .data_o   (spi_data),
    .done_c_o (spi_done_c)
  );

  // Frame sequencer with registered CONVST and sample outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      convst_q  <= 1'b0;
      discard_q <= 1'b1;
      cfg_ch_q  <= '0;
      res_ch_q  <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        // Lock lost: park in IDLE, drop the frame, keep the last sample.
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        convst_q  <= 1'b0;
        discard_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q   <= ST_CONVST;
            convst_q  <= 1'b1;
            cnt_q     <= CNT_W'(CONVST_CYCLES - 1);
            discard_q <= 1'b1;
          end
          ST_CONVST: begin
            if (cnt_q == '0) begin
              state_q  <= ST_CONVERT;
              convst_q <= 1'b0;
              cnt_q    <= CNT_W'(CONV_CYCLES - 1);
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_CONVERT: begin
            if (cnt_q == '0) begin
              state_q  <= ST_SHIFT;
              res_ch_q <= cfg_ch_q;
              cfg_ch_q <= channel;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_SHIFT: begin
            if (spi_done_c) begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (!discard_q) begin
              sample_q.data <= spi_data;
              sample_q.ch   <= res_ch_q;
              valid_q       <= 1'b1;
            end
            discard_q <= 1'b0;
            state_q   <= ST_CONVST;
            convst_q  <= 1'b1;
            cnt_q     <= CNT_W'(CONVST_CYCLES - 1);
          end
          default: begin
            state_q  <= ST_IDLE;
            convst_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_convst     = convst_q;
  assign sample         = sample_q.data;
  assign sample_channel = sample_q.ch;
  assign sample_valid   = valid_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler with a behavioural LTC2308 model and an SDI
// monitor. Default parameters: 91-cycle frames.
module tb_adc_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  channel;
  logic        adc_convst;
  logic        adc_sck;
  logic        adc_sdi;
  logic        adc_sdo = 1'b0;
  logic [11:0] sample;
  logic [2:0]  sample_channel;
  logic        sample_valid;

  int n_vec = 0;
  int n_mis = 0;

  // ADC model / SDI monitor state
  logic [11:0] adc_next  = '0;
  logic [11:0] conv_word = '0;
  bit          rand_mode = 1'b0;
  int          nframe    = 0;
  logic [11:0] words [0:255];
  int          sdo_idx   = 11;
  logic [11:0] sdi_cap   = '0;
  logic [11:0] last_sdi  = '0;
  int          rise_cnt  = 0;
  int          last_rises = 0;
  logic        prev_convst = 1'b0;
  logic        prev_sck    = 1'b0;

  adc_sampler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .channel        (channel),
    .adc_convst     (adc_convst),
    .adc_sck        (adc_sck),
    .adc_sdi        (adc_sdi),
    .adc_sdo        (adc_sdo),
    .sample         (sample),
    .sample_channel (sample_channel),
    .sample_valid   (sample_valid)
  );

  initial forever #10 clk = ~clk;

  // ADC: new word per CONVST rise, next SDO bit after each SCK rise; records SDI.
  always @(negedge clk) begin
    if (adc_convst && !prev_convst) begin
      conv_word = rand_mode ? 12'($urandom_range(0, 4095)) : adc_next;
      if (nframe < 256) words[nframe] = conv_word;
      nframe++;
      sdo_idx    = 11;
      last_sdi   = sdi_cap;
      last_rises = rise_cnt;
      sdi_cap    = '0;
      rise_cnt   = 0;
    end
    if (adc_sck && !prev_sck) begin
      adc_sdo = conv_word[sdo_idx];
      if (sdo_idx > 0) sdo_idx--;
      sdi_cap = {sdi_cap[10:0], adc_sdi};
      rise_cnt++;
    end
    prev_convst = adc_convst;
    prev_sck    = adc_sck;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycles until the next strobe, counted in posedges; bounded.
  task automatic wait_valid(input string tag, input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!sample_valid && cyc < max_cyc);
    check({tag, "_seen"}, 32'(sample_valid), 32'd1);
  endtask

  task automatic check_sample(input string tag, input logic [11:0] d, input logic [2:0] ch);
    check({tag, "_data"}, 32'(sample), 32'(d));
    check({tag, "_ch"}, 32'(sample_channel), 32'(ch));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_convst"}, 32'(adc_convst), 32'd0);
    check({tag, "_sck"}, 32'(adc_sck), 32'd0);
    check({tag, "_sdi"}, 32'(adc_sdi), 32'd0);
    check({tag, "_valid"}, 32'(sample_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int nv, nc, ns;
    int base;
    bit seen;

    rst_n = 1'b0; enable = 1'b0; channel = 3'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    check_sample("reset", 12'h000, 3'd0);
    rst_n = 1'b1;

    // First frame discarded; strobe 2 frames + 1 cycle after enable.
    @(negedge clk);
    channel = 3'd5; adc_next = 12'hA5C; enable = 1'b1;
    wait_valid("s2", 400, cyc);
    check("s2_lat", 32'(cyc), 32'd183);
    check_sample("s2", 12'hA5C, 3'd5);
    adc_next = 12'h3C7; channel = 3'd3;
    @(negedge clk); #1;
    check("f2_sdi", 32'(last_sdi), 32'h0E80);
    check("f2_rises", 32'(last_rises), 32'd12);

    wait_valid("s3", 200, cyc);
    check("s3_gap", 32'(cyc), 32'd91);
    check_sample("s3", 12'h3C7, 3'd5);
    adc_next = 12'h123; channel = 3'd2;
    @(negedge clk); #1;
    check("f3_sdi", 32'(last_sdi), 32'h0D80);
    check("f3_rises", 32'(last_rises), 32'd12);

    wait_valid("s4", 200, cyc);
    check("s4_gap", 32'(cyc), 32'd91);
    check_sample("s4", 12'h123, 3'd3);
    adc_next = 12'h456;
    @(negedge clk); #1;
    check("f4_sdi", 32'(last_sdi), 32'h0980);
    // Switch 2 -> 6 in the middle of CONVERT.
    repeat (29) @(posedge clk);
    @(negedge clk);
    channel = 3'd6;

    wait_valid("s5", 200, cyc);
    check_sample("s5", 12'h456, 3'd2);
    adc_next = 12'h789;
    @(negedge clk); #1;
    check("f5_sdi", 32'(last_sdi), 32'h0B80);

    wait_valid("s6", 200, cyc);
    check("s6_gap", 32'(cyc), 32'd91);
    check_sample("s6", 12'h789, 3'd6);

    // Drop enable during CONVERT.
    repeat (19) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("endrop");
    nv = 0; nc = 0; ns = 0;
    repeat (200) begin
      @(posedge clk); #1;
      nv += int'(sample_valid); nc += int'(adc_convst); ns += int'(adc_sck);
    end
    check("endrop_strobes", 32'(nv), 32'd0);
    check("endrop_convst", 32'(nc), 32'd0);
    check("endrop_sck", 32'(ns), 32'd0);
    check_sample("endrop_hold", 12'h789, 3'd6);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    channel = 3'd1; adc_next = 12'h0F0; enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      seen = adc_sck;
    end
    check("rst_sck_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    check_sample("rst_mid", 12'h000, 3'd0);
    nv = 0;
    repeat (3) begin
      @(posedge clk); #1;
      nv += int'(sample_valid);
    end
    check("rst_no_strobe", 32'(nv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("rst_s2", 400, cyc);
    check("rst_s2_lat", 32'(cyc), 32'd183);
    check_sample("rst_s2", 12'h0F0, 3'd1);

    // Steady run, 100 frames of random words -> 99 strobes.
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rand_mode = 1'b1; channel = 3'd4; base = nframe; enable = 1'b1;
    for (int j = 0; j < 99; j++) begin
      wait_valid("run", 400, cyc);
      check("run_gap", 32'(cyc), (j == 0) ? 32'd183 : 32'd91);
      check_sample("run", words[base + j + 1], 3'd4);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
